// File: rtl/req_ack_arbiter.sv
// Round-robin arbiter that shares one req/ack responder between NREQ requesters.
// It enforces the ack window, the ack timeout and the minimum req spacing.
module req_ack_arbiter #(
  parameter int NREQ    = 4,
  parameter int ACK_LAT = 4,
  parameter int MIN_GAP = 8,
  parameter int TO_CYC  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] src_req,
  output logic [NREQ-1:0] src_grant,
  output logic [NREQ-1:0] src_done,
  output logic            req,
  input  logic            ack,
  output logic            busy,
  output logic            err_unexp,
  output logic            err_timeout,
  output logic [7:0]      req_cnt,
  output logic [7:0]      ack_cnt
);
  localparam int OW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CMAX = (TO_CYC > MIN_GAP) ? TO_CYC : MIN_GAP;
  localparam int SW   = $clog2(CMAX + 2);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t        state;
  logic [OW-1:0] ptr, owner, pick, idx;
  logic [OW:0]   sum;
  logic          found;
  // cycles elapsed since the last issued req; doubles as the ack offset k
  logic [SW-1:0] since, since_nxt;
  logic          started;
  logic          gap_ok, issue, ack_ok, accept, tmo, unexp;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr} + (OW+1)'(i);
      if (sum >= (OW+1)'(NREQ)) sum = sum - (OW+1)'(NREQ);
      idx = sum[OW-1:0];
      if (!found && src_req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // no req yet since reset means the gap window is already closed
  assign gap_ok    = !started || (since >= SW'(MIN_GAP - 1));
  assign issue     = (state == IDLE) && found && gap_ok;
  assign ack_ok    = since >= SW'(ACK_LAT);
  assign accept    = (state == WAIT) && ack && ack_ok;
  assign tmo       = (state == WAIT) && !accept && (since == SW'(TO_CYC));
  assign unexp     = ack && !((state == WAIT) && ack_ok);
  assign since_nxt = issue ? '0 : (&since ? since : since + SW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      owner       <= '0;
      since       <= '0;
      started     <= 1'b0;
      req         <= 1'b0;
      src_grant   <= '0;
      src_done    <= '0;
      busy        <= 1'b0;
      err_unexp   <= 1'b0;
      err_timeout <= 1'b0;
      req_cnt     <= '0;
      ack_cnt     <= '0;
    end else begin
      since     <= since_nxt;
      req       <= issue;
      src_grant <= issue ? ({{(NREQ-1){1'b0}}, 1'b1} << pick) : '0;
      src_done  <= (accept || tmo) ? ({{(NREQ-1){1'b0}}, 1'b1} << owner) : '0;
      busy      <= issue || ((state == WAIT) && !accept && !tmo) ||
                   ((started || issue) && (since_nxt < SW'(MIN_GAP)));
      if (unexp) err_unexp <= 1'b1;
      if (tmo)   err_timeout <= 1'b1;
      if (accept) ack_cnt <= ack_cnt + 8'd1;
      case (state)
        IDLE: if (issue) begin
          state   <= WAIT;
          owner   <= pick;
          ptr     <= (pick == OW'(NREQ - 1)) ? '0 : pick + OW'(1);
          started <= 1'b1;
          req_cnt <= req_cnt + 8'd1;
        end
        WAIT: if (accept || tmo) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_req_ack_arbiter.sv
// Directed bench for req_ack_arbiter at default parameters; expected values are hand-derived.
module tb_req_ack_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] src_req = '0;
  logic       ack = 1'b0;
  logic [3:0] src_grant, src_done;
  logic       req, busy, err_unexp, err_timeout;
  logic [7:0] req_cnt, ack_cnt;

  int checks = 0, errors = 0, cyc_n = 0;
  int t, tp, r;
  logic saw_done;

  req_ack_arbiter #(.NREQ(4), .ACK_LAT(4), .MIN_GAP(8), .TO_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .src_req(src_req), .src_grant(src_grant),
    .src_done(src_done), .req(req), .ack(ack), .busy(busy),
    .err_unexp(err_unexp), .err_timeout(err_timeout),
    .req_cnt(req_cnt), .ack_cnt(ack_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // each cycle is observed and driven 1ns after its rising edge
  task automatic cyc();
    @(posedge clk); #1; cyc_n++;
  endtask

  task automatic cycn(input int n);
    repeat (n) cyc();
  endtask

  task automatic do_reset(input logic [3:0] sr);
    rst_n = 1'b0; ack = 1'b0; src_req = '0;
    cycn(2);
    src_req = sr; rst_n = 1'b1; r = cyc_n;
  endtask

  task automatic wait_req(output int tr);
    int n;
    n = 0;
    while (req !== 1'b1 && n < 40) begin cyc(); n++; end
    chk("req_seen", {31'd0, req}, 32'd1);
    tr = cyc_n;
  endtask

  // from cycle t: ack at t+4, return in cycle t+5
  task automatic ack_at4();
    cycn(4); ack = 1'b1; cyc(); ack = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_outs", {req, src_grant, src_done, busy, err_unexp, err_timeout}, 0);
    chk("rst_cnts", {req_cnt, ack_cnt}, 0);

    // single transaction, requester 0
    do_reset(4'b0001);
    wait_req(t);
    chk("first_req_lat", t - r, 1);
    chk("t28_grant", src_grant, 4'b0001);
    chk("t28_busy_t", busy, 1);
    src_req = '0;
    cycn(3);
    chk("t28_nodone_t3", src_done, 0);
    cyc(); ack = 1'b1;
    cyc(); ack = 1'b0;
    chk("t28_done_t5", src_done, 4'b0001);
    chk("t28_ackcnt", ack_cnt, 1);
    chk("t28_reqcnt", req_cnt, 1);
    cycn(2);
    chk("t28_busy_t7", busy, 1);
    cyc();
    chk("t28_busy_t8", busy, 0);

    // all requesters held: round-robin at 8-cycle spacing
    do_reset(4'b1111);
    tp = 0;
    for (int i = 0; i < 5; i++) begin
      wait_req(t);
      chk("t29_grant", src_grant, 32'd1 << (i % 4));
      if (i > 0) chk("t29_spacing", t - tp, 8);
      tp = t;
      if (i == 4) src_req = '0;
      ack_at4();
      chk("t29_done", src_done, 32'd1 << (i % 4));
    end
    chk("t29_cnts", {req_cnt, ack_cnt}, {8'd5, 8'd5});
    chk("t29_noerr", {err_unexp, err_timeout}, 0);

    // timeout on requester 1
    do_reset(4'b0010);
    wait_req(t);
    chk("t30_grant", src_grant, 4'b0010);
    cycn(16);
    chk("t30_to_t16", {err_timeout, src_done}, 0);
    cyc();
    chk("t30_to_t17", err_timeout, 1);
    chk("t30_done_t17", src_done, 4'b0010);
    chk("t30_req_t17", req, 0);
    cyc();
    chk("t30_req_t18", {req, src_grant}, {1'b1, 4'b0010});
    src_req = '0;
    ack_at4();
    chk("t30_done2", src_done, 4'b0010);
    chk("t30_sticky", err_timeout, 1);
    chk("t30_cnts", {req_cnt, ack_cnt}, {8'd2, 8'd1});

    // early ack flags error, later ack accepted
    do_reset(4'b0001);
    wait_req(t);
    src_req = '0;
    cycn(2); ack = 1'b1;
    cyc(); ack = 1'b0;
    chk("t31_unexp_t3", err_unexp, 1);
    chk("t31_nodone_t3", src_done, 0);
    cyc(); ack = 1'b1;
    cyc(); ack = 1'b0;
    chk("t31_done_t5", src_done, 4'b0001);
    chk("t31_ackcnt", ack_cnt, 1);
    cyc(); ack = 1'b1;
    cyc(); ack = 1'b0;
    chk("t31_unexp_t7", err_unexp, 1);
    chk("t31_ackcnt_t7", ack_cnt, 1);
    chk("t31_nodone_t7", src_done, 0);

    // reset in the middle of WAIT
    do_reset(4'b0001);
    wait_req(t);
    src_req = '0;
    cycn(2);
    rst_n = 1'b0;
    #1;
    chk("t32_outs", {req, src_grant, src_done, busy, err_unexp, err_timeout}, 0);
    chk("t32_cnts", {req_cnt, ack_cnt}, 0);
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (src_done != 0) saw_done = 1'b1;
    end
    chk("t32_nodone", {31'd0, saw_done}, 0);
    src_req = 4'b0001; rst_n = 1'b1;
    cyc();
    chk("t32_req_first", {req, src_grant}, {1'b1, 4'b0001});

    // counter wrap after 256 transactions
    do_reset(4'b0001);
    for (int i = 0; i < 256; i++) begin
      wait_req(t);
      if (i == 255) src_req = '0;
      ack_at4();
      if (i == 254) chk("t33_cnt255", {req_cnt, ack_cnt}, {8'd255, 8'd255});
    end
    chk("t33_wrap", {req_cnt, ack_cnt}, 0);
    chk("t33_done", src_done, 4'b0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
